// File: rtl/rrp_pkg.sv
// rtl/rrp_pkg.sv - shared widths, digit/transfer types and transfer codes for the online adder
package rrp_pkg;

  typedef logic signed [1:0] xfer_t;
  // Widest digit the block supports (RADIX=16)
  typedef logic signed [4:0] digit_t;

  localparam xfer_t T_POS  = 2'sb01;
  localparam xfer_t T_ZERO = 2'sb00;
  localparam xfer_t T_NEG  = 2'sb11;

  function automatic int digit_bits(input int radix);
    return $clog2(radix) + 1;
  endfunction

  function automatic int total_bits(input int radix, input int width);
    return digit_bits(radix) * width;
  endfunction

  function automatic int xfer_bits(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/rrp_add_pipe_if.sv
// rtl/rrp_add_pipe_if.sv - operand/result handshake bundle for the online adder
interface rrp_add_pipe_if
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 15
);
  localparam int D = digit_bits(RADIX);
  localparam int N = total_bits(RADIX, WIDTH);

  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [N-1:0] x_in;
  logic [N-1:0] y_in;
  logic         out_valid;
  logic         out_ready;
  logic [N+D-1:0] s_out;
  logic         err_digit;

  modport master (
    output in_valid, in_sub, x_in, y_in, out_ready,
    input  in_ready, out_valid, s_out, err_digit
  );

  modport slave (
    input  in_valid, in_sub, x_in, y_in, out_ready,
    output in_ready, out_valid, s_out, err_digit
  );
endinterface

// File: rtl/rrp_digit_slice.sv
// rtl/rrp_digit_slice.sv - one digit position: optional y negation, transfer and interim sum
module rrp_digit_slice
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  localparam int D = digit_bits(RADIX)
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         sub,
  output xfer_t        t,
  output logic [D-1:0] w
);
  localparam logic signed [D:0] A_POS = (D+1)'(RADIX - 1);
  localparam logic signed [D:0] A_NEG = -A_POS;
  localparam logic signed [D:0] R     = (D+1)'(RADIX);

  logic [D-1:0]    y_eff;
  logic signed [D:0] p;

  // p is one bit wider than a digit so 2*A (and the illegal -RADIX code) cannot wrap
  always_comb begin
    y_eff = sub ? -y : y;
    p     = $signed({x[D-1], x}) + $signed({y_eff[D-1], y_eff});
    if (p >= A_POS) begin
      t = T_POS;
      w = D'(p - R);
    end else if (p <= A_NEG) begin
      t = T_NEG;
      w = D'(p + R);
    end else begin
      t = T_ZERO;
      w = p[D-1:0];
    end
  end
endmodule

// File: rtl/rrp_add_pipe.sv
// rtl/rrp_add_pipe.sv - pipelined signed-digit online adder/subtractor with valid/ready
module rrp_add_pipe
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 15,
  parameter int PIPE  = 1
) (
  input logic          clock,
  input logic          reset,
  rrp_add_pipe_if.slave bus
);
  localparam int D  = digit_bits(RADIX);
  localparam int N  = total_bits(RADIX, WIDTH);
  localparam int TN = xfer_bits(WIDTH);
  localparam logic [D-1:0] BAD_CODE = {1'b1, {(D-1){1'b0}}};

  logic advance, accept, illegal;
  logic out_v, err_q;
  logic [N+D-1:0] s_q, s_c;

  assign advance       = !out_v || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_v;
  assign bus.s_out     = s_q;
  assign bus.err_digit = err_q;

  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.x_in[i*D +: D] == BAD_CODE || bus.y_in[i*D +: D] == BAD_CODE)
        illegal = 1'b1;
    end
  end

  logic [N-1:0] x_q, y_q;
  logic         sub_q, v_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      v_in  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      sub_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (advance) begin
        v_in  <= bus.in_valid;
        x_q   <= bus.x_in;
        y_q   <= bus.y_in;
        sub_q <= bus.in_sub;
      end
      if (accept && illegal)
        err_q <= 1'b1;
    end
  end

  logic [N-1:0]  w_c, w_s;
  logic [TN-1:0] t_c, t_s;
  logic          v_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    rrp_digit_slice #(.RADIX(RADIX)) u_slice (
      .x   (x_q[i*D +: D]),
      .y   (y_q[i*D +: D]),
      .sub (sub_q),
      .t   (t_c[2*i +: 2]),
      .w   (w_c[i*D +: D])
    );
  end

  if (PIPE == 2) begin : g_pipe2
    logic [N-1:0]  w_q;
    logic [TN-1:0] t_q;
    logic          v_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        v_q <= 1'b0;
        w_q <= '0;
        t_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        w_q <= w_c;
        t_q <= t_c;
      end
    end
    assign w_s = w_q;
    assign t_s = t_q;
    assign v_s = v_q;
  end else begin : g_pipe1
    assign w_s = w_c;
    assign t_s = t_c;
    assign v_s = v_in;
  end

  // Each digit absorbs the transfer from the position below; the top digit is the last transfer
  always_comb begin
    s_c = '0;
    s_c[0 +: D] = w_s[0 +: D];
    for (int i = 1; i < WIDTH; i++)
      s_c[i*D +: D] = w_s[i*D +: D] + {{(D-2){t_s[2*i-1]}}, t_s[2*(i-1) +: 2]};
    s_c[WIDTH*D +: D] = {{(D-2){t_s[TN-1]}}, t_s[TN-2 +: 2]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_v <= 1'b0;
      s_q   <= '0;
    end else if (advance) begin
      out_v <= v_s;
      s_q   <= s_c;
    end
  end
endmodule

// File: tb/tb_rrp_add_pipe.sv
// tb/tb_rrp_add_pipe.sv - scoreboard bench for rrp_add_pipe at RADIX=4 WIDTH=4, PIPE 1 and 2
module tb_rrp_add_pipe;
  localparam int N  = 12;
  localparam int SW = 15;
  localparam int K_EXACT = 0;
  localparam int K_VALUE = 1;
  localparam int K_SKIP  = 2;

  typedef struct {
    int          kind;
    logic [SW-1:0] s;
    longint      val;
  } exp_t;

  logic clock, reset;
  int   n_cmp, n_bad;
  int   outs_a, outs_b;
  exp_t ea, eb;
  exp_t qa[$], qb[$];

  rrp_add_pipe_if #(.RADIX(4), .WIDTH(4)) ia ();
  rrp_add_pipe_if #(.RADIX(4), .WIDTH(4)) ib ();

  rrp_add_pipe #(.RADIX(4), .WIDTH(4), .PIPE(1)) dut_a (.clock(clock), .reset(reset), .bus(ia.slave));
  rrp_add_pipe #(.RADIX(4), .WIDTH(4), .PIPE(2)) dut_b (.clock(clock), .reset(reset), .bus(ib.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Directed vectors, digits packed 3 bits each, expected sums hand-derived
  logic [N-1:0]  dx   [8] = '{12'o3333, 12'o3610, 12'o0000, 12'o0005, 12'o0001, 12'o0007, 12'o5000, 12'o0003};
  logic [N-1:0]  dy   [8] = '{12'o3333, 12'o3610, 12'o0001, 12'o0005, 12'o0002, 12'o0002, 12'o5000, 12'o0005};
  logic          dsub [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [SW-1:0] ds   [8] = '{15'o13332, 15'o00000, 15'o00007, 15'o00076, 15'o00017, 15'o00071, 15'o76000, 15'o00012};

  function automatic exp_t mk(input int kind, input logic [SW-1:0] s, input longint val);
    exp_t e;
    e.kind = kind;
    e.s    = s;
    e.val  = val;
    return e;
  endfunction

  function automatic longint sval(input logic [SW-1:0] s);
    longint v;
    logic [2:0] d;
    v = 0;
    for (int i = 4; i >= 0; i--) begin
      d = s[i*3 +: 3];
      v = v * 4 + longint'($signed(d));
    end
    return v;
  endfunction

  function automatic bit in_range(input logic [SW-1:0] s);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++)
      if (s[i*3 +: 3] == 3'b100) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input exp_t e, input logic [SW-1:0] s);
    if (e.kind == K_EXACT) begin
      chk(name, 64'(s), 64'(e.s));
    end else if (e.kind == K_VALUE) begin
      n_cmp++;
      if (sval(s) != e.val || !in_range(s) || $isunknown(s)) begin
        n_bad++;
        $display("FAIL %s_value: got s=%0o (value %0d) expected value %0d", name, s, sval(s), e.val);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ia.in_valid && ia.in_ready) qa.push_back(ea);
      if (ib.in_valid && ib.in_ready) qb.push_back(eb);
      if (ia.out_valid && ia.out_ready) begin
        outs_a++;
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL p1_unexpected_output: got s=%0o expected none", ia.s_out);
        end else check_out("p1_sum", qa.pop_front(), ia.s_out);
      end
      if (ib.out_valid && ib.out_ready) begin
        outs_b++;
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL p2_unexpected_output: got s=%0o expected none", ib.s_out);
        end else check_out("p2_sum", qb.pop_front(), ib.s_out);
      end
    end
  end

  task automatic set_ready(input logic r);
    ia.out_ready = r;
    ib.out_ready = r;
  endtask

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic sub,
                      input exp_t e, input bit rnd_ready);
    bit da, db;
    int guard;
    da = 0; db = 0; guard = 0;
    ia.x_in = x; ia.y_in = y; ia.in_sub = sub; ia.in_valid = 1'b1;
    ib.x_in = x; ib.y_in = y; ib.in_sub = sub; ib.in_valid = 1'b1;
    ea = e; eb = e;
    while (!(da && db) && guard < 200) begin
      @(negedge clock);
      if (ia.in_valid && ia.in_ready) da = 1;
      if (ib.in_valid && ib.in_ready) db = 1;
      @(posedge clock); #1;
      if (da) ia.in_valid = 1'b0;
      if (db) ib.in_valid = 1'b0;
      if (rnd_ready) set_ready($urandom_range(0, 3) != 0);
      guard++;
    end
    if (!(da && db)) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got accepted a=%0d b=%0d expected both", da, db);
      ia.in_valid = 1'b0;
      ib.in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Feed directed ops 0..3 to each DUT independently for a number of cycles
  task automatic feed(input int cycles, inout int na, inout int nb);
    for (int c = 0; c < cycles; c++) begin
      ia.in_valid = (na < 4);
      ib.in_valid = (nb < 4);
      if (na < 4) begin
        ia.x_in = dx[na]; ia.y_in = dy[na]; ia.in_sub = dsub[na]; ea = mk(K_EXACT, ds[na], 0);
      end
      if (nb < 4) begin
        ib.x_in = dx[nb]; ib.y_in = dy[nb]; ib.in_sub = dsub[nb]; eb = mk(K_EXACT, ds[nb], 0);
      end
      @(negedge clock);
      if (ia.in_valid && ia.in_ready) na++;
      if (ib.in_valid && ib.in_ready) nb++;
      @(posedge clock); #1;
    end
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
  endtask

  initial begin
    int na, nb, snap_a, snap_b, dv;
    logic [N-1:0] x, y;
    logic sub;
    longint vx, vy;
    n_cmp = 0; n_bad = 0; outs_a = 0; outs_b = 0;
    ea = mk(K_SKIP, '0, 0); eb = ea;
    reset = 1'b1;
    ia.in_valid = 0; ia.in_sub = 0; ia.x_in = '0; ia.y_in = '0;
    ib.in_valid = 0; ib.in_sub = 0; ib.x_in = '0; ib.y_in = '0;
    set_ready(1'b1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    idle(1);

    chk("rst_out_valid_p1", 64'(ia.out_valid), 0);
    chk("rst_out_valid_p2", 64'(ib.out_valid), 0);
    chk("rst_in_ready_p1", 64'(ia.in_ready), 1);
    chk("rst_in_ready_p2", 64'(ib.in_ready), 1);
    chk("rst_err_p1", 64'(ia.err_digit), 0);
    chk("rst_err_p2", 64'(ib.err_digit), 0);
    chk("rst_s_out_p1", 64'(ia.s_out), 0);
    chk("rst_s_out_p2", 64'(ib.s_out), 0);

    for (int i = 0; i < 8; i++)
      send(dx[i], dy[i], dsub[i], mk(K_EXACT, ds[i], 0), 1'b0);
    idle(6);

    for (int k = 0; k < 1000; k++) begin
      x = '0; y = '0; vx = 0; vy = 0;
      for (int i = 0; i < 4; i++) begin
        dv = int'($urandom_range(0, 6)) - 3;
        x[i*3 +: 3] = dv[2:0];
        vx += longint'(dv) * (64'sd1 << (2*i));
        dv = int'($urandom_range(0, 6)) - 3;
        y[i*3 +: 3] = dv[2:0];
        vy += longint'(dv) * (64'sd1 << (2*i));
      end
      sub = $urandom_range(0, 1) != 0;
      send(x, y, sub, mk(K_VALUE, '0, sub ? vx - vy : vx + vy), 1'b1);
    end
    set_ready(1'b1);
    idle(8);

    set_ready(1'b0);
    na = 0; nb = 0;
    feed(5, na, nb);
    chk("stall_accepted_p1", 64'(na), 2);
    chk("stall_accepted_p2", 64'(nb), 3);
    chk("stall_in_ready_p1", 64'(ia.in_ready), 0);
    chk("stall_in_ready_p2", 64'(ib.in_ready), 0);
    set_ready(1'b1);
    snap_a = outs_a; snap_b = outs_b;
    feed(4, na, nb);
    chk("release_burst_p1", 64'(outs_a - snap_a), 4);
    chk("release_burst_p2", 64'(outs_b - snap_b), 4);
    idle(6);

    send(dx[0], dy[0], dsub[0], mk(K_EXACT, ds[0], 0), 1'b0);
    send(dx[6], dy[6], dsub[6], mk(K_EXACT, ds[6], 0), 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst_out_valid_p1", 64'(ia.out_valid), 0);
    chk("midrst_out_valid_p2", 64'(ib.out_valid), 0);
    chk("midrst_in_ready_p1", 64'(ia.in_ready), 1);
    idle(6);

    chk("pre_err_p1", 64'(ia.err_digit), 0);
    send(12'o0004, 12'o0000, 1'b0, mk(K_SKIP, '0, 0), 1'b0);
    chk("err_set_p1", 64'(ia.err_digit), 1);
    chk("err_set_p2", 64'(ib.err_digit), 1);
    send(dx[4], dy[4], dsub[4], mk(K_EXACT, ds[4], 0), 1'b0);
    send(dx[5], dy[5], dsub[5], mk(K_EXACT, ds[5], 0), 1'b0);
    idle(6);
    chk("err_held_p1", 64'(ia.err_digit), 1);
    chk("err_held_p2", 64'(ib.err_digit), 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("err_clear_p1", 64'(ia.err_digit), 0);
    chk("err_clear_p2", 64'(ib.err_digit), 0);

    send(dx[7], dy[7], dsub[7], mk(K_EXACT, ds[7], 0), 1'b0);
    idle(8);
    chk("drain_queue_p1", 64'(qa.size()), 0);
    chk("drain_queue_p2", 64'(qb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
